// File: rtl/oh_fifo_wr_pkg.sv
// Shared types for the FIFO write-side adapter: skid buffer state and occupancy width.
package oh_fifo_wr_pkg;

  localparam int unsigned OCC_W = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_t;

  function automatic logic [OCC_W-1:0] state_occ(input skid_state_t s);
    case (s)
      EMPTY:   return 2'd0;
      ONE:     return 2'd1;
      TWO:     return 2'd2;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/oh_fifo_wr_if.sv
// Ingress valid/ready stream plus FIFO write port of the write-side adapter.
interface oh_fifo_wr_if #(
  parameter int unsigned DW = 10
) ();

  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          fifo_full;
  logic          fifo_prog_full;
  logic          fifo_wr_en;
  logic [DW-1:0] fifo_din;

  modport master (
    output in_valid, in_data, fifo_full, fifo_prog_full,
    input  in_ready, fifo_wr_en, fifo_din
  );

  modport slave (
    input  in_valid, in_data, fifo_full, fifo_prog_full,
    output in_ready, fifo_wr_en, fifo_din
  );

endinterface

// File: rtl/oh_skid2.sv
// Two-entry skid buffer; in_ready is derived from registers and flush only.
module oh_skid2
  import oh_fifo_wr_pkg::*;
#(
  parameter int unsigned DW = 10
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [DW-1:0]    in_data,
  input  logic             pop,
  output logic             in_ready,
  output logic [DW-1:0]    head,
  output skid_state_t      state,
  output logic [OCC_W-1:0] occ
);

  logic          rdy_en;
  logic [DW-1:0] skid;
  logic          accept;

  assign in_ready = rdy_en & (state != TWO) & ~flush;
  assign accept   = in_valid & in_ready;
  assign occ      = state_occ(state);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state  <= EMPTY;
      head   <= '0;
      skid   <= '0;
      rdy_en <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (flush) begin
        state <= EMPTY;
      end else begin
        case (state)
          EMPTY: begin
            if (accept) begin
              head  <= in_data;
              state <= ONE;
            end
          end
          ONE: begin
            // Accept and pop together keep occupancy at one: new word replaces head.
            if (accept && pop) begin
              head <= in_data;
            end else if (accept) begin
              skid  <= in_data;
              state <= TWO;
            end else if (pop) begin
              state <= EMPTY;
            end
          end
          TWO: begin
            if (pop) begin
              head  <= skid;
              state <= ONE;
            end
          end
          default: state <= EMPTY;
        endcase
      end
    end
  end

endmodule

// File: rtl/oh_fifo_wr_adapter.sv
// Write-side producer front-end for the async FIFO: skid buffering, full/prog_full
// gating, write statistics, flush and a sticky ingress protocol-error flag.
module oh_fifo_wr_adapter
  import oh_fifo_wr_pkg::*;
#(
  parameter int unsigned DW       = 10,
  parameter int unsigned THROTTLE = 0,
  parameter int unsigned CW       = 16
) (
  input  logic             wr_clk,
  input  logic             wr_nreset,
  oh_fifo_wr_if.slave      bus,
  input  logic             flush,
  input  logic             clr,
  output logic [OCC_W-1:0] occ,
  output logic [CW-1:0]    wr_words,
  output logic [CW-1:0]    stall_cycles,
  output logic             err_proto
);

  localparam logic THR = (THROTTLE != 0);

  skid_state_t   state;
  logic [DW-1:0] head;
  logic          pending;
  logic          throttled;
  logic          pop;
  logic          stall;

  logic          prev_blocked;
  logic          prev_flush;
  logic [DW-1:0] prev_data;
  logic          proto_viol;

  assign pending   = (state != EMPTY);
  assign throttled = THR & bus.fifo_prog_full;
  assign pop       = pending & ~bus.fifo_full & ~throttled & ~flush;
  assign stall     = pending & ~pop & ~flush;

  assign bus.fifo_wr_en = pop;
  assign bus.fifo_din   = head;

  oh_skid2 #(.DW(DW)) u_skid (
    .clk      (wr_clk),
    .nreset   (wr_nreset),
    .flush    (flush),
    .in_valid (bus.in_valid),
    .in_data  (bus.in_data),
    .pop      (pop),
    .in_ready (bus.in_ready),
    .head     (head),
    .state    (state),
    .occ      (occ)
  );

  // A word offered but refused must be re-offered unchanged next cycle, unless a flush intervened.
  assign proto_viol = prev_blocked & ~prev_flush &
                      (~bus.in_valid | (bus.in_data != prev_data));

  always_ff @(posedge wr_clk or negedge wr_nreset) begin
    if (!wr_nreset) begin
      prev_blocked <= 1'b0;
      prev_flush   <= 1'b0;
      prev_data    <= '0;
      wr_words     <= '0;
      stall_cycles <= '0;
      err_proto    <= 1'b0;
    end else begin
      prev_blocked <= bus.in_valid & ~bus.in_ready;
      prev_flush   <= flush;
      prev_data    <= bus.in_data;
      if (clr) begin
        wr_words     <= '0;
        stall_cycles <= '0;
        err_proto    <= 1'b0;
      end else begin
        if (pop)
          wr_words <= wr_words + CW'(1);
        if (stall && (stall_cycles != '1))
          stall_cycles <= stall_cycles + CW'(1);
        if (proto_viol)
          err_proto <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_oh_fifo_wr_adapter.sv
// Scoreboard bench for oh_fifo_wr_adapter: directed stimulus, negedge monitor checks write order.
module tb_oh_fifo_wr_adapter;

  localparam int unsigned DW = 10;
  localparam int unsigned CW = 5;

  logic          wr_clk = 1'b0;
  logic          wr_nreset;
  logic          flush;
  logic          clr;
  logic [1:0]    occ;
  logic [CW-1:0] wr_words;
  logic [CW-1:0] stall_cycles;
  logic          err_proto;

  int unsigned   n_tests = 0;
  int unsigned   n_fail  = 0;
  logic [DW-1:0] sb[$];

  oh_fifo_wr_if #(.DW(DW)) bus ();

  oh_fifo_wr_adapter #(.DW(DW), .THROTTLE(1), .CW(CW)) dut (
    .wr_clk       (wr_clk),
    .wr_nreset    (wr_nreset),
    .bus          (bus),
    .flush        (flush),
    .clr          (clr),
    .occ          (occ),
    .wr_words     (wr_words),
    .stall_cycles (stall_cycles),
    .err_proto    (err_proto)
  );

  always #5 wr_clk = ~wr_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge wr_clk);
    #1;
  endtask

  // Monitor: compare each FIFO write against the oldest accepted word.
  always @(negedge wr_clk) begin
    if (wr_nreset) begin
      if (bus.fifo_wr_en) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_write: got din 0x%0h expected no write", bus.fifo_din);
        end else begin
          chk("fifo_din_order", 32'(bus.fifo_din), 32'(sb.pop_front()));
        end
      end
      if (flush) sb.delete();
      if (bus.in_valid && bus.in_ready) sb.push_back(bus.in_data);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    wr_nreset = 1'b0; flush = 1'b0; clr = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    bus.fifo_full = 1'b0; bus.fifo_prog_full = 1'b0;

    // reset values
    #2;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_wr_en", bus.fifo_wr_en, 0);
    chk("rst_din", bus.fifo_din, 0);
    chk("rst_occ", occ, 0);
    chk("rst_wr_words", wr_words, 0);
    chk("rst_stall", stall_cycles, 0);
    chk("rst_err", err_proto, 0);
    #10 wr_nreset = 1'b1;
    #1 chk("in_ready_before_edge", bus.in_ready, 0);
    step();
    chk("in_ready_after_edge", bus.in_ready, 1);
    chk("idle_wr_en", bus.fifo_wr_en, 0);

    // back-to-back stream 0x001..0x010
    for (int i = 1; i <= 16; i++) begin
      bus.in_valid = 1'b1; bus.in_data = DW'(i);
      #1 chk("stream_wr_en", bus.fifo_wr_en, 32'(i > 1));
      step();
    end
    bus.in_valid = 1'b0;
    #1 chk("stream_last_wr_en", bus.fifo_wr_en, 1);
    step();
    chk("stream_occ", occ, 0);
    chk("stream_wr_words", wr_words, 16);
    chk("stream_stall", stall_cycles, 0);

    // fifo_full held 5 cycles while streaming
    bus.in_valid = 1'b1; bus.in_data = 10'h101; step();
    bus.fifo_full = 1'b1; bus.in_data = 10'h102; step();
    bus.in_data = 10'h103;
    #1 chk("full_occ2", occ, 2);
    chk("full_in_ready", bus.in_ready, 0);
    chk("full_wr_en", bus.fifo_wr_en, 0);
    repeat (4) step();
    bus.fifo_full = 1'b0;
    #1 chk("full_stall5", stall_cycles, 5);
    chk("full_release_wr_en", bus.fifo_wr_en, 1);
    step();
    chk("full_reaccept_ready", bus.in_ready, 1);
    step();
    bus.in_valid = 1'b0;
    step();
    chk("full_drain_occ", occ, 0);
    chk("full_wr_words", wr_words, 19);
    chk("full_err", err_proto, 0);

    clr = 1'b1; step(); clr = 1'b0;
    #1 chk("clr_wr_words", wr_words, 0);
    chk("clr_stall", stall_cycles, 0);

    // prog_full throttling with one word buffered
    bus.in_valid = 1'b1; bus.in_data = 10'h201; step();
    bus.in_valid = 1'b0; bus.fifo_prog_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("thr_wr_en", bus.fifo_wr_en, 0);
      chk("thr_occ", occ, 1);
      step();
    end
    bus.fifo_prog_full = 1'b0;
    #1 chk("thr_release_wr_en", bus.fifo_wr_en, 1);
    chk("thr_stall3", stall_cycles, 3);
    step();
    chk("thr_occ_end", occ, 0);
    chk("thr_wr_words", wr_words, 1);

    // flush with two words buffered
    bus.fifo_full = 1'b1; bus.in_valid = 1'b1; bus.in_data = 10'h301; step();
    bus.in_data = 10'h302; step();
    bus.in_valid = 1'b0; bus.fifo_full = 1'b0; flush = 1'b1;
    #1 chk("flush_occ_before", occ, 2);
    chk("flush_wr_en", bus.fifo_wr_en, 0);
    chk("flush_in_ready", bus.in_ready, 0);
    step();
    flush = 1'b0;
    #1 chk("flush_occ_after", occ, 0);
    chk("flush_ready_after", bus.in_ready, 1);
    bus.in_valid = 1'b1; bus.in_data = 10'h2AA; step();
    bus.in_valid = 1'b0;
    #1 chk("post_flush_wr_en", bus.fifo_wr_en, 1);
    chk("post_flush_din", bus.fifo_din, 10'h2AA);
    step();
    chk("post_flush_wr_words", wr_words, 2);
    chk("post_flush_stall", stall_cycles, 4);
    chk("post_flush_err", err_proto, 0);

    // valid dropped before acceptance
    bus.fifo_full = 1'b1; bus.in_valid = 1'b1; bus.in_data = 10'h3A1; step();
    bus.in_data = 10'h3A2; step();
    bus.in_data = 10'h3A3; step();
    bus.in_valid = 1'b0;
    #1 chk("drop_err_before", err_proto, 0);
    step();
    chk("drop_err_set", err_proto, 1);
    bus.fifo_full = 1'b0;
    step(); step();
    chk("drop_err_sticky", err_proto, 1);
    chk("drop_occ", occ, 0);
    chk("drop_wr_words", wr_words, 4);
    clr = 1'b1; step(); clr = 1'b0;
    #1 chk("clr_err", err_proto, 0);
    chk("clr_wr_words2", wr_words, 0);
    chk("clr_stall2", stall_cycles, 0);

    // data changed before acceptance
    bus.fifo_full = 1'b1; bus.in_valid = 1'b1; bus.in_data = 10'h3B1; step();
    bus.in_data = 10'h3B2; step();
    bus.in_data = 10'h3B3; step();
    bus.in_data = 10'h3B4;
    #1 chk("chg_err_before", err_proto, 0);
    step();
    chk("chg_err_set", err_proto, 1);
    bus.in_valid = 1'b0; bus.fifo_full = 1'b0;
    step(); step();
    chk("chg_wr_words", wr_words, 2);
    clr = 1'b1; step(); clr = 1'b0;

    // stall counter saturation (CW=5 -> 31)
    bus.fifo_full = 1'b1; bus.in_valid = 1'b1; bus.in_data = 10'h3C1; step();
    bus.in_valid = 1'b0;
    repeat (40) step();
    chk("sat_stall", stall_cycles, 31);
    chk("sat_occ", occ, 1);
    bus.fifo_full = 1'b0;
    step(); step();
    chk("sat_wr_words", wr_words, 1);

    // word counter wrap: 33 writes mod 32 = 1
    clr = 1'b1; step(); clr = 1'b0;
    for (int i = 0; i < 33; i++) begin
      bus.in_valid = 1'b1; bus.in_data = DW'(i + 'h40);
      step();
    end
    bus.in_valid = 1'b0;
    step(); step();
    chk("wrap_wr_words", wr_words, 1);

    // asynchronous reset mid-operation
    bus.fifo_full = 1'b1; bus.in_valid = 1'b1; bus.in_data = 10'h3D1; step();
    bus.in_data = 10'h3D2; step();
    bus.in_valid = 1'b0;
    #1 chk("mid_occ_before", occ, 2);
    wr_nreset = 1'b0; sb.delete();
    #1 chk("mid_occ", occ, 0);
    chk("mid_in_ready", bus.in_ready, 0);
    chk("mid_wr_en", bus.fifo_wr_en, 0);
    chk("mid_din", bus.fifo_din, 0);
    chk("mid_wr_words", wr_words, 0);
    chk("mid_stall", stall_cycles, 0);
    bus.fifo_full = 1'b0;
    #10 wr_nreset = 1'b1;
    #1 chk("mid_ready_before_edge", bus.in_ready, 0);
    step();
    chk("mid_ready_after_edge", bus.in_ready, 1);
    bus.in_valid = 1'b1; bus.in_data = 10'h3E1; step();
    bus.in_valid = 1'b0;
    step(); step();
    chk("mid_post_wr_words", wr_words, 1);
    chk("mid_post_occ", occ, 0);

    chk("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/oh_fifo_wr_adapter.md
Name: oh_fifo_wr_adapter

Overview:
- Write-side producer front-end for the generic async FIFO, running entirely in the wr_clk domain.
- Accepts a valid/ready stream and buffers it in a 2-entry skid buffer, so in_ready depends only on state registers.
- Drives the FIFO write port (wr_en/din), honouring full and, optionally, prog_full.
- Provides write statistics, a synchronous flush and a sticky protocol-error flag.

Parameters:
- DW, 10, data width; must match the FIFO DW.
- THROTTLE, 0, 1 = also stall egress while fifo_prog_full is high; 0 = stall on fifo_full only.
- CW, 16, width of the word and stall statistics counters.

Ports:
- wr_clk  in  1  write clock.
- wr_nreset  in  1  asynchronous, active-low reset, wr_clk domain.
- in_valid  in  1  ingress word valid.
- in_data  in  DW  ingress word.
- in_ready  out  1  adapter can accept a word this cycle.
- flush  in  1  synchronous: discard all buffered words.
- clr  in  1  synchronous: clear err_proto and both counters.
- fifo_full  in  1  FIFO full flag.
- fifo_prog_full  in  1  FIFO programmable-full flag.
- fifo_wr_en  out  1  FIFO write enable.
- fifo_din  out  DW  FIFO write data.
- occ  out  2  buffered word count (0..2).
- wr_words  out  CW  words written to the FIFO; wraps at 2^CW.
- stall_cycles  out  CW  cycles with a word pending but not written; saturates at all-ones.
- err_proto  out  1  sticky ingress protocol violation.

Behaviour:
- Reset: all state registers clear asynchronously on wr_nreset low.
  - Output values during reset: occ=0, in_ready=0, fifo_wr_en=0, fifo_din=0, wr_words=0, stall_cycles=0, err_proto=0.
  - in_ready rises on the first wr_clk edge after reset deassertion, via a registered rdy_en flop.
- Skid states (package enum): EMPTY (occ 0), ONE (occ 1), TWO (occ 2).
  - Entries: head register (drives fifo_din) and skid register.
- in_ready = rdy_en & (state != TWO) & ~flush. It is a function of registers and flush only; it never depends on in_valid or fifo_full.
- Accept = in_valid & in_ready. Pop = fifo_wr_en.
- fifo_wr_en = (state != EMPTY) & ~fifo_full & ~(THROTTLE & fifo_prog_full) & ~flush.
- fifo_din = head register. Its value is held, not zeroed, when state is EMPTY.
- Transitions:
  - EMPTY + accept -> ONE; the word is loaded into head.
  - ONE + accept & ~pop -> TWO; the word goes to skid.
  - ONE + accept & pop -> ONE; head is loaded with the new word.
  - ONE + pop & ~accept -> EMPTY.
  - TWO + pop -> ONE; skid moves to head. Accept is impossible in TWO.
  - No accept and no pop: state holds.
- Latency: a word accepted at edge N is presented on fifo_din with fifo_wr_en at cycle N+1 if unblocked. Sustained throughput is 1 word/cycle.
- Ordering: strictly FIFO. No word is ever duplicated or dropped except by flush.
- Flush: at the next edge, state -> EMPTY and skid contents are discarded. fifo_wr_en and in_ready are both 0 during the flush cycle. Counters are unaffected.
- Simultaneous flush & clr: both take effect.
- wr_words increments by 1 on each pop and wraps modulo 2^CW.
- stall_cycles increments on each cycle with (state != EMPTY) & ~fifo_wr_en & ~flush. It saturates at 2^CW-1.
- clr takes priority over increments in the same cycle; the counter results after that edge are 0.
- err_proto is set, sticky, when a word was offered but not accepted in the previous cycle (in_valid & ~in_ready) and in the current cycle either:
  - in_valid is low, or
  - in_data differs from the previous cycle's data.
  It is suppressed if flush was high in the previous cycle. It is cleared only by clr or reset.
- fifo_full asserting while in ONE/TWO: head is held and fifo_wr_en=0. When full deasserts, the word is written unchanged.
- Reset mid-operation: buffered words are lost and outputs return to their reset values immediately (asynchronous).

Decomposition:
- Package oh_fifo_wr_pkg:
  - skid state enum (EMPTY/ONE/TWO, 2 bits);
  - occupancy width constant (2).
- One natural sub-module: oh_skid2 (2-entry skid buffer: state, head, skid, in_ready, occ).
  - The top level adds the FIFO gating, counters, error detection and flush/clr handling.

Test Plan:
- Reset release, in_valid=0 -> in_ready 0 in the reset cycle, 1 after the first edge; fifo_wr_en=0; occ=0; counters=0.
- Stream 0x001..0x010 back-to-back, fifo_full=0 -> fifo_wr_en high for 16 consecutive cycles starting 1 cycle after the first accept; fifo_din in order; wr_words=16; stall_cycles=0.
- Hold fifo_full=1 for 5 cycles while streaming -> occ reaches 2; in_ready=0; stall_cycles=5; on release, words drain in order with none lost.
- THROTTLE=1, fifo_full=0, fifo_prog_full=1 for 3 cycles with occ=1 -> fifo_wr_en=0 for those 3 cycles; stall_cycles=3.
- occ=2 then flush=1 for one cycle -> occ=0 next cycle; no fifo_wr_en during flush; subsequent word 0x2AA is the next fifo_din.
- Backpressure via full, drop in_valid before acceptance -> err_proto=1 and stays 1; clr=1 -> err_proto=0, wr_words=0, stall_cycles=0.
